// File: rtl/key_mmio_irq.sv
// key_mmio_irq: keyboard MMIO slave and interrupt source for the riscv64 core.
// Key bytes from the scanner are queued in a small FIFO. The core reads them
// through a 32-byte register window. An interrupt request with an
// ack / mret handshake tells the core that bytes are waiting.
module key_mmio_irq #(
    parameter logic [63:0] KEY_BASE   = 64'h0000_0000_0000_2000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [3:0]  IRQ_VEC    = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    output logic        bus_hit,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    output logic [3:0]  interrupt_vector,
    input  logic        interrupt_ack,
    input  logic        interrupt_pending
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SERVICE
    } irq_state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow;
    logic             irq_en;

    logic             in_window;
    logic [1:0]       reg_offset;
    logic             txn_busy;
    logic             txn_start;
    logic             wr_txn;
    logic             rd_txn;
    logic             do_pop;
    logic             do_push;
    logic             overflow_set;
    logic             overflow_clear;
    logic [63:0]      status_word;
    logic [63:0]      read_value;

    irq_state_t       irq_state;
    irq_state_t       irq_next;

    logic             unused_bits;

    // Address bits [2:0] and most store-data bits carry no meaning in this window.
    assign unused_bits = ^{bus_address[2:0], bus_write_data[63:11], bus_write_data[9:1]};

    // The window is 32-byte aligned, so the upper address bits are compared directly.
    assign in_window  = (bus_address[63:5] == KEY_BASE[63:5]);
    assign reg_offset = bus_address[4:3];
    assign bus_hit    = in_window && (bus_read_enable || bus_write_enable);

    // A transaction is the first cycle of a hit. A write wins over a simultaneous read.
    assign txn_start = bus_hit && !txn_busy;
    assign wr_txn    = txn_start && bus_write_enable;
    assign rd_txn    = txn_start && bus_read_enable && !bus_write_enable;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);

    // A DATA read with an empty FIFO has no side effect.
    // A push into a full FIFO succeeds only when a pop makes room on the same edge.
    assign do_pop         = rd_txn && (reg_offset == OFF_DATA) && !fifo_empty;
    assign do_push        = key_valid && (!fifo_full || do_pop);
    assign overflow_set   = key_valid && fifo_full && !do_pop;
    assign overflow_clear = wr_txn && (reg_offset == OFF_STATUS) && bus_write_data[10];

    assign status_word = {53'd0, overflow, fifo_full, fifo_empty, 8'(count)};

    // Tracks whether the current hit has already been consumed.
    // Dropping the enables or leaving the window re-arms it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txn_busy <= 1'b0;
        end else begin
            txn_busy <= bus_hit;
        end
    end

    // Selects the register image returned for a read transaction.
    always_comb begin
        read_value = '0;
        case (reg_offset)
            OFF_DATA: begin
                if (!fifo_empty) begin
                    read_value = {56'd0, fifo_mem[rd_ptr]};
                end
            end
            OFF_STATUS: read_value = status_word;
            OFF_CTRL:   read_value = {63'd0, irq_en};
            default:    read_value = '0;
        endcase
    end

    // Load data is captured on the starting edge and held until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_read_data <= '0;
        end else if (rd_txn) begin
            bus_read_data <= read_value;
        end
    end

    // FIFO storage. The contents need no reset because pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= key_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    // The count changes only when exactly one of push and pop happens.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The sticky overflow flag wins over a clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (overflow_set) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

    // The interrupt enable bit is written through CTRL bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
        end else if (wr_txn && (reg_offset == OFF_CTRL)) begin
            irq_en <= bus_write_data[0];
        end
    end

    // Interrupt handshake state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_state <= IRQ_IDLE;
        end else begin
            irq_state <= irq_next;
        end
    end

    // Request while enabled bytes wait. Wait in SERVICE until the core's mret drops pending.
    always_comb begin
        irq_next = irq_state;
        case (irq_state)
            IRQ_IDLE: begin
                if (irq_en && !fifo_empty) begin
                    irq_next = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (interrupt_ack) begin
                    irq_next = IRQ_SERVICE;
                end else if (!irq_en || fifo_empty) begin
                    irq_next = IRQ_IDLE;
                end
            end
            IRQ_SERVICE: begin
                if (!interrupt_pending) begin
                    irq_next = IRQ_IDLE;
                end
            end
            default: irq_next = IRQ_IDLE;
        endcase
    end

    // The vector is registered from the next state, so it follows the condition by one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            interrupt_vector <= '0;
        end else begin
            interrupt_vector <= (irq_next == IRQ_REQ) ? IRQ_VEC : 4'd0;
        end
    end

endmodule

// File: tb/tb_key_mmio_irq.sv
// tb_key_mmio_irq: directed and randomized bus/key traffic against a
// queue-based model of the keyboard register window.
module tb_key_mmio_irq;

    localparam logic [63:0] KEY_BASE = 64'h0000_0000_0000_2000;
    localparam int          DEPTH    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        bus_hit;
    logic        key_valid;
    logic [7:0]  key_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;
    logic        interrupt_pending;

    int tests    = 0;
    int failures = 0;

    logic [7:0]  model_q[$];
    logic        model_ovf;
    logic        model_irq_en;
    logic        model_prev_hit;
    logic [63:0] model_rd;

    key_mmio_irq dut (
        .clk               (clk),
        .reset             (reset),
        .bus_address       (bus_address),
        .bus_write_data    (bus_write_data),
        .bus_write_enable  (bus_write_enable),
        .bus_read_enable   (bus_read_enable),
        .bus_read_data     (bus_read_data),
        .bus_hit           (bus_hit),
        .key_valid         (key_valid),
        .key_data          (key_data),
        .interrupt_vector  (interrupt_vector),
        .interrupt_ack     (interrupt_ack),
        .interrupt_pending (interrupt_pending)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Stops a hung run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic inWindow(input logic [63:0] a);
        return (a >= KEY_BASE) && (a < KEY_BASE + 64'd32);
    endfunction

    task automatic modelReset();
        model_q.delete();
        model_ovf      = 1'b0;
        model_irq_en   = 1'b0;
        model_prev_hit = 1'b0;
        model_rd       = '0;
    endtask

    // One clock cycle of stimulus. The model applies the register-map rules to the values before the edge.
    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] wdata, input logic we,
                                 input logic re, input logic kv, input logic [7:0] kd, input logic ack);
        logic       hit;
        logic       start;
        logic       popped;
        logic       ovf_set;
        logic       ovf_clr;
        logic [1:0] off;
        int         pre_size;
        @(negedge clk);
        bus_address      = addr;
        bus_write_data   = wdata;
        bus_write_enable = we;
        bus_read_enable  = re;
        key_valid        = kv;
        key_data         = kd;
        interrupt_ack    = ack;
        @(posedge clk);
        hit            = inWindow(addr) && (we || re);
        start          = hit && !model_prev_hit;
        model_prev_hit = hit;
        off            = 2'((addr - KEY_BASE) >> 3);
        pre_size       = model_q.size();
        popped         = 1'b0;
        ovf_set        = 1'b0;
        ovf_clr        = 1'b0;
        if (start && re && !we) begin
            case (off)
                2'd0: begin
                    if (pre_size > 0) begin
                        model_rd = {56'd0, model_q[0]};
                        popped   = 1'b1;
                    end else begin
                        model_rd = '0;
                    end
                end
                2'd1: model_rd = (model_ovf ? 64'h400 : 64'h0) | ((pre_size == DEPTH) ? 64'h200 : 64'h0)
                               | ((pre_size == 0) ? 64'h100 : 64'h0) | 64'(pre_size);
                2'd2: model_rd = {63'd0, model_irq_en};
                default: model_rd = '0;
            endcase
        end
        if (start && we) begin
            if (off == 2'd1 && wdata[10]) ovf_clr = 1'b1;
            if (off == 2'd2) model_irq_en = wdata[0];
        end
        if (popped) model_q.delete(0);
        if (kv) begin
            if (pre_size < DEPTH || popped) model_q.push_back(kd);
            else ovf_set = 1'b1;
        end
        if (ovf_set) model_ovf = 1'b1;
        else if (ovf_clr) model_ovf = 1'b0;
        #1;
        checkOutput("bus_hit", 64'(bus_hit), 64'(hit));
        checkOutput("read_data", bus_read_data, model_rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0);
    endtask

    task automatic pushKey(input logic [7:0] b);
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic readReg(input logic [63:0] off, output logic [63:0] data);
        applyStimulus(KEY_BASE + off, 64'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
        data = bus_read_data;
        idle(1);
    endtask

    task automatic writeReg(input logic [63:0] off, input logic [63:0] wdata);
        applyStimulus(KEY_BASE + off, wdata, 1'b1, 1'b0, 1'b0, 8'h0, 1'b0);
        idle(1);
    endtask

    task automatic waitVector(input logic [3:0] expected, input int max_cycles, input string tag);
        int n = 0;
        while (interrupt_vector !== expected && n < max_cycles) begin
            idle(1);
            n++;
        end
        checkOutput(tag, 64'(interrupt_vector), 64'(expected));
    endtask

    // Stimulus sequence.
    initial begin
        logic [63:0] rd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        we;
        logic        re;

        reset             = 1'b0;
        bus_address       = '0;
        bus_write_data    = '0;
        bus_write_enable  = 1'b0;
        bus_read_enable   = 1'b0;
        key_valid         = 1'b0;
        key_data          = '0;
        interrupt_ack     = 1'b0;
        interrupt_pending = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_vector", 64'(interrupt_vector), 64'h0);
        checkOutput("reset_read_data", bus_read_data, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // A single key with interrupts disabled.
        pushKey(8'h41);
        readReg(64'h08, rd); checkOutput("status_one", rd, 64'h001);
        readReg(64'h00, rd); checkOutput("data_one", rd, 64'h41);
        readReg(64'h08, rd); checkOutput("status_empty", rd, 64'h100);
        checkOutput("no_irq_disabled", 64'(interrupt_vector), 64'h0);

        // Overflow: nine pushes into eight entries.
        for (int i = 0; i < 9; i++) pushKey(8'h30 + 8'(i));
        readReg(64'h08, rd); checkOutput("status_full_ovf", rd, 64'h608);
        for (int i = 0; i < 8; i++) begin
            readReg(64'h00, rd);
            checkOutput("data_ovf_order", rd, 64'h30 + 64'(i));
        end
        readReg(64'h08, rd); checkOutput("status_ovf_sticky", rd, 64'h500);
        writeReg(64'h08, 64'h400);
        readReg(64'h08, rd); checkOutput("status_ovf_clear", rd, 64'h100);

        // A read enable held for three cycles pops only once.
        pushKey(8'h71);
        pushKey(8'h72);
        for (int i = 0; i < 3; i++) applyStimulus(KEY_BASE, 64'h0, 1'b0, 1'b1, 1'b0, 8'h0, 1'b0);
        checkOutput("held_read_first", bus_read_data, 64'h71);
        idle(1);
        readReg(64'h00, rd); checkOutput("held_read_second", rd, 64'h72);
        readReg(64'h08, rd); checkOutput("held_status", rd, 64'h100);

        // A push and a pop on the same edge.
        pushKey(8'h61); pushKey(8'h62); pushKey(8'h63);
        applyStimulus(KEY_BASE, 64'h0, 1'b0, 1'b1, 1'b1, 8'h64, 1'b0);
        checkOutput("pushpop_data", bus_read_data, 64'h61);
        idle(1);
        readReg(64'h08, rd); checkOutput("pushpop_count", rd, 64'h003);
        for (int i = 0; i < 3; i++) begin
            readReg(64'h00, rd);
            checkOutput("pushpop_order", rd, 64'h62 + 64'(i));
        end
        readReg(64'h00, rd); checkOutput("pop_empty", rd, 64'h0);
        applyStimulus(KEY_BASE, 64'h0, 1'b0, 1'b1, 1'b1, 8'h65, 1'b0);
        checkOutput("pushpop_empty", bus_read_data, 64'h0);
        idle(1);
        readReg(64'h00, rd); checkOutput("pushpop_empty_byte", rd, 64'h65);

        // Interrupt handshake.
        writeReg(64'h10, 64'h1);
        readReg(64'h10, rd); checkOutput("ctrl_read", rd, 64'h1);
        checkOutput("irq_idle_empty", 64'(interrupt_vector), 64'h0);
        pushKey(8'h41);
        waitVector(4'd1, 2, "irq_raise");
        interrupt_pending = 1'b1;
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1);
        checkOutput("irq_ack_drop", 64'(interrupt_vector), 64'h0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checkOutput("irq_service_hold", 64'(interrupt_vector), 64'h0);
        end
        interrupt_pending = 1'b0;
        waitVector(4'd1, 4, "irq_rerequest");
        readReg(64'h00, rd); checkOutput("irq_data", rd, 64'h41);
        waitVector(4'd0, 3, "irq_empty_drop");
        writeReg(64'h10, 64'h0);

        // Asynchronous reset in the middle of a serviced interrupt.
        writeReg(64'h10, 64'h1);
        for (int i = 0; i < 6; i++) pushKey(8'h50 + 8'(i));
        waitVector(4'd1, 3, "rst_irq_raise");
        interrupt_pending = 1'b1;
        applyStimulus(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1);
        readReg(64'h00, rd); checkOutput("rst_pre_data", rd, 64'h50);
        readReg(64'h08, rd); checkOutput("rst_pre_count", rd, 64'h005);
        checkOutput("rst_pre_service", 64'(interrupt_vector), 64'h0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async_vector", 64'(interrupt_vector), 64'h0);
        checkOutput("rst_async_read_data", bus_read_data, 64'h0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        interrupt_pending = 1'b0;
        readReg(64'h08, rd); checkOutput("rst_count", rd, 64'h100);
        readReg(64'h10, rd); checkOutput("rst_irq_en", rd, 64'h0);
        idle(2);
        checkOutput("rst_vector_quiet", 64'(interrupt_vector), 64'h0);

        // Randomized traffic checked against the queue model.
        addr  = KEY_BASE;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 4) != 0) addr = KEY_BASE + 64'($urandom_range(0, 31));
                else if ($urandom_range(0, 1) != 0) addr = KEY_BASE + 64'd32 + 64'($urandom_range(0, 63));
                else addr = 64'h1000 + 64'($urandom_range(0, 4095));
                wdata = {$urandom, $urandom};
                we    = ($urandom_range(0, 3) == 0);
                re    = ($urandom_range(0, 1) == 0);
            end
            applyStimulus(addr, wdata, we, re,
                          ($urandom_range(0, 9) < (((i / 100) % 2 == 0) ? 7 : 2)),
                          8'($urandom), 1'b0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
